// File: rtl/pool_3_buffer_if.sv
// Handshake/data bundle between the layer-3 pool stage, this buffer and the layer-4 conv stage.
interface pool_3_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              layer_4_begin;
    logic [DATA_W-1:0] d_in;
    logic              relu_3_ready;
    logic              relu_3_complete;
    logic              rd_en;
    logic [ADDR_W-1:0] layer_4_read_addr;
    logic [DATA_W-1:0] d_out;
    logic              layer_4_ready;
    logic              layer_4_write_comp;
    logic              overflow_err;
    logic              short_err;

    modport master (
        output layer_4_begin, d_in, relu_3_ready, relu_3_complete, rd_en, layer_4_read_addr,
        input  d_out, layer_4_ready, layer_4_write_comp, overflow_err, short_err
    );

    modport slave (
        input  layer_4_begin, d_in, relu_3_ready, relu_3_complete, rd_en, layer_4_read_addr,
        output d_out, layer_4_ready, layer_4_write_comp, overflow_err, short_err
    );
endinterface

// File: rtl/pool_3_buffer.sv
// Layer-3 pooled feature-map buffer: raster capture, early/complete ready flags, and a
// registered read-first random read port for layer 4.
//
// state | meaning
// IDLE  | waiting for layer_4_begin, strobes ignored
// FILL  | capturing strobes into the buffer in raster order
// FULL  | map complete (or cut short); strobes flag overflow
module pool_3_buffer #(
    parameter int DATA_W     = 8,
    parameter int FEAT_W     = 12,
    parameter int FEAT_H     = 12,
    parameter int ADDR_W     = 8,
    parameter int READY_ROWS = 3
) (
    input  logic            clk,
    input  logic            rst,
    pool_3_buffer_if.slave  bus
);
    localparam int TOTAL = FEAT_W * FEAT_H;
    localparam logic [ADDR_W:0] TOTAL_A  = (ADDR_W+1)'(TOTAL);
    localparam logic [ADDR_W:0] THRESH_A = (ADDR_W+1)'(READY_ROWS * FEAT_W);
    localparam logic [ADDR_W:0] ONE_A    = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic              ready_q, ready_d;
    logic              comp_q, comp_d;
    logic              ovf_q, ovf_d;
    logic              short_q, short_d;

    logic              wr_en, last_wr, short_evt, ovf_evt;

    logic [DATA_W-1:0] mem_q [TOTAL];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.layer_4_begin) begin
            state_d = S_FILL;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_FILL: if (last_wr || short_evt) state_d = S_FULL;
                S_FULL: if (!bus.relu_3_complete) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // begin always wins over a coincident strobe or completion
    always_comb begin
        wr_en     = (state_q == S_FILL) && bus.relu_3_ready && !bus.layer_4_begin;
        last_wr   = wr_en && (wr_addr_q == TOTAL_A - ONE_A);
        short_evt = (state_q == S_FILL) && bus.relu_3_complete && !bus.layer_4_begin && !last_wr;
        ovf_evt   = (state_q == S_FULL) && bus.relu_3_ready && !bus.layer_4_begin;
    end

    always_comb begin
        wr_addr_d = wr_addr_q;
        ready_d   = ready_q;
        comp_d    = comp_q;
        ovf_d     = ovf_q;
        short_d   = short_q;
        if (bus.layer_4_begin) begin
            wr_addr_d = '0;
            ready_d   = 1'b0;
            comp_d    = 1'b0;
            ovf_d     = 1'b0;
            short_d   = 1'b0;
        end else begin
            if (wr_en) wr_addr_d = wr_addr_q + ONE_A;
            if (wr_en && (wr_addr_q + ONE_A >= THRESH_A)) ready_d = 1'b1;
            if (last_wr || short_evt) comp_d = 1'b1;
            if (ovf_evt) ovf_d = 1'b1;
            if (short_evt) short_d = 1'b1;
        end
    end

    // mem_q is sampled before this edge's write lands, giving read-first behaviour
    always_comb begin
        d_out_d = d_out_q;
        if (bus.rd_en) begin
            if ({1'b0, bus.layer_4_read_addr} < TOTAL_A) d_out_d = mem_q[bus.layer_4_read_addr];
            else                                          d_out_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr_q <= '0;
            d_out_q   <= '0;
            ready_q   <= 1'b0;
            comp_q    <= 1'b0;
            ovf_q     <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            d_out_q   <= d_out_d;
            ready_q   <= ready_d;
            comp_q    <= comp_d;
            ovf_q     <= ovf_d;
            short_q   <= short_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr_q[ADDR_W-1:0]] <= bus.d_in;
    end

    assign bus.d_out              = d_out_q;
    assign bus.layer_4_ready      = ready_q;
    assign bus.layer_4_write_comp = comp_q;
    assign bus.overflow_err       = ovf_q;
    assign bus.short_err          = short_q;
endmodule

// File: tb/tb_pool_3_buffer.sv
// Directed bench for pool_3_buffer: fill/readback, overflow, begin collision, short map,
// mid-fill reset and read-first collision.
module tb_pool_3_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pool_3_buffer_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    pool_3_buffer #(
        .DATA_W(8), .FEAT_W(12), .FEAT_H(12), .ADDR_W(8), .READY_ROWS(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat (3) tick();
    endtask

    task automatic strobe(input logic [7:0] d);
        bus.d_in         = d;
        bus.relu_3_ready = 1'b1;
        tick();
        bus.relu_3_ready = 1'b0;
    endtask

    task automatic begin_pulse();
        bus.layer_4_begin = 1'b1;
        tick();
        bus.layer_4_begin = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        bus.rd_en             = 1'b1;
        bus.layer_4_read_addr = a;
        tick();
        bus.rd_en             = 1'b0;
        chk(name, bus.d_out, exp);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_dout"},  bus.d_out, 0);
        chk({name, "_ready"}, bus.layer_4_ready, 0);
        chk({name, "_comp"},  bus.layer_4_write_comp, 0);
        chk({name, "_ovf"},   bus.overflow_err, 0);
        chk({name, "_short"}, bus.short_err, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{1'b1, 8'd143, 8'd143};
        vecs[1] = '{1'b0, 8'd0,   8'd143};
        vecs[2] = '{1'b1, 8'd150, 8'd0};
        vecs[3] = '{1'b0, 8'd143, 8'd0};
        vecs[4] = '{1'b1, 8'd1,   8'd1};
        vecs[5] = '{1'b1, 8'd144, 8'd0};
        vecs[6] = '{1'b1, 8'd12,  8'd12};
        vecs[7] = '{1'b1, 8'd255, 8'd0};

        rst = 1'b0;
        bus.layer_4_begin     = 1'b0;
        bus.d_in              = '0;
        bus.relu_3_ready      = 1'b0;
        bus.relu_3_complete   = 1'b0;
        bus.rd_en             = 1'b0;
        bus.layer_4_read_addr = '0;
        #22;
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // 1: full fill, complete raised together with the final strobe
        begin_pulse();
        for (int i = 0; i < 144; i++) begin
            if (i == 143) bus.relu_3_complete = 1'b1;
            strobe(8'(i));
            if (i == 34)  chk("t1_ready_before", bus.layer_4_ready, 0);
            if (i == 35)  chk("t1_ready_at36", bus.layer_4_ready, 1);
            if (i == 142) chk("t1_comp_before", bus.layer_4_write_comp, 0);
            if (i == 143) chk("t1_comp_at144", bus.layer_4_write_comp, 1);
            gap();
        end
        chk("t1_short", bus.short_err, 0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 144; i++) begin
            bus.layer_4_read_addr = 8'(i);
            tick();
            if (bus.d_out !== 8'(i)) chk("t1_readback", bus.d_out, 8'(i));
            else                     checks++;
        end
        bus.rd_en = 1'b0;

        // 2: overflow in FULL, then table-driven reads
        strobe(8'hAA);
        tick();
        chk("t2_ovf", bus.overflow_err, 1);
        chk("t2_ready_held", bus.layer_4_ready, 1);
        for (int v = 0; v < 8; v++) begin
            bus.rd_en             = vecs[v].rd;
            bus.layer_4_read_addr = vecs[v].addr;
            tick();
            chk($sformatf("t2_vec%0d", v), bus.d_out, vecs[v].exp);
        end
        bus.rd_en = 1'b0;
        bus.relu_3_complete = 1'b0;
        tick();

        // 3: begin coincident with a strobe drops the sample
        bus.layer_4_begin = 1'b1;
        strobe(8'h55);
        bus.layer_4_begin = 1'b0;
        chk("t3_ovf_cleared", bus.overflow_err, 0);
        chk("t3_comp_cleared", bus.layer_4_write_comp, 0);
        chk("t3_ready_cleared", bus.layer_4_ready, 0);
        for (int k = 0; k < 144; k++) begin
            strobe((k == 5) ? 8'h22 : 8'(k + 1));
            if (k == 0)   rd(8'd0, 8'd1, "t3_addr0");
            if (k == 142) chk("t3_comp_before", bus.layer_4_write_comp, 0);
            if (k == 143) chk("t3_comp_at144", bus.layer_4_write_comp, 1);
            gap();
        end
        tick();
        chk("t3_comp_held_idle", bus.layer_4_write_comp, 1);
        rd(8'd5, 8'h22, "t3_addr5");
        rd(8'd143, 8'h90, "t3_addr143");

        // 6: same-cycle write and read of addr 5 is read-first
        begin_pulse();
        for (int k = 0; k < 5; k++) strobe(8'(k));
        bus.rd_en             = 1'b1;
        bus.layer_4_read_addr = 8'd5;
        strobe(8'h11);
        chk("t6_read_old", bus.d_out, 8'h22);
        tick();
        chk("t6_read_new", bus.d_out, 8'h11);
        bus.rd_en = 1'b0;

        // 4: short completion after 100 strobes
        begin_pulse();
        for (int k = 0; k < 100; k++) strobe(8'(k));
        chk("t4_no_short_yet", bus.short_err, 0);
        bus.relu_3_complete = 1'b1;
        tick();
        chk("t4_short", bus.short_err, 1);
        chk("t4_comp", bus.layer_4_write_comp, 1);
        chk("t4_ovf_before", bus.overflow_err, 0);
        strobe(8'h99);
        chk("t4_ovf", bus.overflow_err, 1);
        bus.relu_3_complete = 1'b0;
        tick();

        // 5: asynchronous reset mid-fill
        begin_pulse();
        for (int k = 0; k < 50; k++) begin
            strobe(8'(8'h40 + k));
            gap();
        end
        rd(8'd1, 8'h41, "t5_pre_read");
        chk("t5_pre_ready", bus.layer_4_ready, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("t5_async");
        tick();
        rst = 1'b1;
        tick();
        strobe(8'hEE);
        gap();
        chk("t5_idle_ovf", bus.overflow_err, 0);
        chk("t5_idle_ready", bus.layer_4_ready, 0);
        begin_pulse();
        strobe(8'h77);
        rd(8'd0, 8'h77, "t5_restart_addr0");
        for (int k = 1; k < 36; k++) begin
            strobe(8'(k));
            if (k == 34) chk("t5_ready_before", bus.layer_4_ready, 0);
            if (k == 35) chk("t5_ready_at36", bus.layer_4_ready, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
